// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg
//   Shared constants and types for the HI/LO sequencer and its register file.
//   - TIMEOUT_DEFAULT : default cycle bound for a RUN or DRAIN phase
//   - ST_*            : 3-bit sequencer state encoding
//   - hilo_t          : {hi, lo} result pair as delivered by mult/div units
package hilo_ctrl_pkg;

  localparam int TIMEOUT_DEFAULT = 40;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_MULT_RUN = 3'd1;
  localparam logic [2:0] ST_DIV_RUN  = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_ZERO     = 3'd4;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs
//   Architectural HI/LO register pair. A result load from the mult/div unit
//   overrides an mthi/mtlo write to the same word on the same edge.
//   Ports:
//     Clk, Reset : clock, asynchronous active-high reset (clears both words)
//     load       : load both words from load_val
//     load_val   : {hi, lo} result from the active unit
//     hi_we      : mthi write enable (already qualified by the sequencer)
//     lo_we      : mtlo write enable (already qualified by the sequencer)
//     wdata      : mthi/mtlo data
//     hilo       : current register contents, zero read latency
module hilo_regs
  import hilo_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        load,
  input  hilo_t       load_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output hilo_t       hilo
);

  // Word 1 is HI, word 0 is LO.
  logic [1:0][31:0] ld_word;
  logic [1:0]       we;
  logic [1:0][31:0] word;

  assign ld_word = {load_val.hi, load_val.lo};
  assign we      = {hi_we, lo_we};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          word_reg <= '0;
        end else if (load) begin
          word_reg <= ld_word[gi];
        end else if (we[gi]) begin
          word_reg <= wdata;
        end
      end

      assign word[gi] = word_reg;
    end
  endgenerate

  assign hilo = {word[1], word[0]};

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl
//   Sequencer between the control unit and the mult/div datapath units.
//   Starts the requested unit, holds its start line through the unit's
//   hold-start handshake, captures the 64-bit result into HI/LO, and raises
//   divide-by-zero / timeout pulses. Ocupado stalls the control unit while an
//   operation is in flight.
//   Ports:
//     Clk, Reset            : clock, asynchronous active-high reset
//     OpMult, OpDiv         : operation requests (sampled only in IDLE)
//     DivisorIn             : divisor, checked for zero at request time
//     HiWrite, LoWrite      : mthi / mtlo (accepted only in IDLE)
//     WriteData             : mthi / mtlo data
//     MultStart/MultFim/... : multiplier handshake and result words
//     DivStart/DivFim/...   : divider handshake, remainder (Hi), quotient (Lo)
//     HiOut, LoOut          : architectural HI/LO
//     Ocupado               : busy / stall
//     OpFim                 : one-cycle pulse after HI/LO took a result
//     ExcDivZero            : one-cycle pulse, divide by zero
//     ExcTimeout            : one-cycle pulse, unit never answered / released
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OpMult,
  input  logic        OpDiv,
  input  logic [31:0] DivisorIn,
  input  logic        HiWrite,
  input  logic        LoWrite,
  input  logic [31:0] WriteData,
  output logic        MultStart,
  input  logic        MultFim,
  input  logic [31:0] MultHi,
  input  logic [31:0] MultLo,
  output logic        DivStart,
  input  logic        DivFim,
  input  logic [31:0] DivHi,
  input  logic [31:0] DivLo,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        Ocupado,
  output logic        OpFim,
  output logic        ExcDivZero,
  output logic        ExcTimeout
);

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  // Remembers which unit owns the DRAIN phase.
  logic          div_sel_reg, div_sel_next;
  logic          op_fim_reg, op_fim_next;
  logic          exc_to_reg, exc_to_next;

  logic  fim_sel;
  logic  cnt_last;
  logic  load;
  hilo_t result_val;
  hilo_t hilo_q;

  assign fim_sel    = div_sel_reg ? DivFim : MultFim;
  assign cnt_last   = (cnt_reg == CW'(TIMEOUT - 1));
  assign result_val = div_sel_reg ? {DivHi, DivLo} : {MultHi, MultLo};

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    div_sel_next = div_sel_reg;
    op_fim_next  = 1'b0;
    exc_to_next  = 1'b0;
    load         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (OpMult) begin
          // Multiply wins over a simultaneous divide request.
          state_next   = ST_MULT_RUN;
          div_sel_next = 1'b0;
        end else if (OpDiv) begin
          if (DivisorIn == 32'd0) begin
            state_next = ST_ZERO;
          end else begin
            state_next   = ST_DIV_RUN;
            div_sel_next = 1'b1;
          end
        end
      end
      ST_MULT_RUN, ST_DIV_RUN: begin
        if (fim_sel) begin
          load        = 1'b1;
          op_fim_next = 1'b1;
          state_next  = ST_DRAIN;
          cnt_next    = '0;
        end else if (cnt_last) begin
          exc_to_next = 1'b1;
          state_next  = ST_IDLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_DRAIN: begin
        // Start stays high until the unit drops Fim, so it can rewind its
        // internal counter before the next request.
        if (!fim_sel) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_last) begin
          exc_to_next = 1'b1;
          state_next  = ST_IDLE;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_ZERO: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      div_sel_reg <= 1'b0;
      op_fim_reg  <= 1'b0;
      exc_to_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      div_sel_reg <= div_sel_next;
      op_fim_reg  <= op_fim_next;
      exc_to_reg  <= exc_to_next;
    end
  end

  hilo_regs u_regs (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (load),
    .load_val (result_val),
    .hi_we    (HiWrite && (state_reg == ST_IDLE)),
    .lo_we    (LoWrite && (state_reg == ST_IDLE)),
    .wdata    (WriteData),
    .hilo     (hilo_q)
  );

  // Start lines decode straight from state so they fall with Reset at once;
  // div_sel_reg keeps them mutually exclusive during DRAIN.
  assign MultStart  = (state_reg == ST_MULT_RUN) || ((state_reg == ST_DRAIN) && !div_sel_reg);
  assign DivStart   = (state_reg == ST_DIV_RUN)  || ((state_reg == ST_DRAIN) &&  div_sel_reg);
  assign Ocupado    = (state_reg != ST_IDLE);
  assign ExcDivZero = (state_reg == ST_ZERO);
  assign OpFim      = op_fim_reg;
  assign ExcTimeout = exc_to_reg;
  assign HiOut      = hilo_q.hi;
  assign LoOut      = hilo_q.lo;

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sequencer and HI/LO register file between the control unit and the mult/div datapath blocks.
- Accepts a mult or div request, drives the unit's start line through that unit's hold-start handshake, and captures the 64-bit result into architectural HI/LO.
- Raises divide-by-zero and timeout exceptions.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Holds Ocupado high so the control unit stalls while an operation is in flight.

Parameters:
- TIMEOUT, 40, maximum cycles in a RUN state before the operation is aborted (div needs 34 clock edges).
- CW, $clog2(TIMEOUT+1), cycle-counter width.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; clears all state.
- OpMult  in  1  request signed multiply (sampled in IDLE).
- OpDiv  in  1  request signed divide (sampled in IDLE).
- DivisorIn  in  32  divisor operand, checked for zero at request time.
- HiWrite  in  1  mthi: HI <= WriteData.
- LoWrite  in  1  mtlo: LO <= WriteData.
- WriteData  in  32  mthi/mtlo data.
- MultStart  out  1  start/hold line to multiplier.
- MultFim  in  1  multiplier done.
- MultHi  in  32  multiplier upper result word.
- MultLo  in  32  multiplier lower result word.
- DivStart  out  1  start/hold line to divider.
- DivFim  in  1  divider done.
- DivHi  in  32  remainder.
- DivLo  in  32  quotient.
- HiOut  out  32  HI register.
- LoOut  out  32  LO register.
- Ocupado  out  1  busy/stall.
- OpFim  out  1  one-cycle pulse: HI/LO updated by a mult/div.
- ExcDivZero  out  1  one-cycle pulse: divide by zero.
- ExcTimeout  out  1  one-cycle pulse: unit never answered.

Behaviour:
- Reset (async, any time including mid-operation):
  - State IDLE; HiOut, LoOut, counter = 0.
  - MultStart, DivStart, Ocupado, OpFim, ExcDivZero, ExcTimeout = 0.
- States: IDLE, MULT_RUN, DIV_RUN, DRAIN, ZERO.
- IDLE:
  - Ocupado=0.
  - HiWrite/LoWrite apply this edge. Both may apply together.
  - OpMult=1 -> MULT_RUN. OpMult has priority; a simultaneous OpDiv is dropped.
  - Else OpDiv=1 and DivisorIn==0 -> ZERO. The divider is never started, so its sticky flags are never set.
  - Else OpDiv=1 -> DIV_RUN.
  - A mthi/mtlo and a request on the same edge: the write happens and the later result overwrites it.
- ZERO:
  - One cycle; ExcDivZero=1, Ocupado=1, HI/LO unchanged.
  - Next edge -> IDLE.
- MULT_RUN / DIV_RUN:
  - Ocupado=1; the selected start line is held at 1.
  - Counter increments each cycle.
  - Fim sampled 1 on an edge: HI/LO load {MultHi,MultLo} or {DivHi,DivLo} on that edge; OpFim=1 the following cycle; -> DRAIN.
  - Counter reaches TIMEOUT with Fim=0: start line drops; ExcTimeout pulse; HI/LO unchanged; -> IDLE.
- DRAIN:
  - Start line stays 1 until Fim is sampled 0. The unit needs that extra edge to return its counter to 0; dropping start earlier leaves it mid-count.
  - Then start=0 -> IDLE.
  - Ocupado stays 1 throughout DRAIN.
  - DRAIN is also bounded by TIMEOUT; overflow -> ExcTimeout, -> IDLE.
- Requests, HiWrite and LoWrite arriving while Ocupado=1 are ignored. The control unit must hold them until Ocupado=0.
- Mult and div start lines are never high together.
- HiOut and LoOut are direct register outputs with zero read latency.
- The datapath units may clock on the opposite edge; only their Fim and result ports are sampled, and only on posedge.

Decomposition:
- Shared package/header:
  - state encoding (3 bits: IDLE=0, MULT_RUN=1, DIV_RUN=2, DRAIN=3, ZERO=4);
  - default TIMEOUT.
- One natural sub-module: hilo_regs, holding the two 32-bit registers with priority result-load > mthi/mtlo. Sequencer FSM and counter stay in hilo_ctrl.

Test Plan:
1. Div: DivisorIn=7, unit returns DivHi=2, DivLo=14 after 34 edges -> HiOut=2, LoOut=14, one OpFim pulse, Ocupado low after DRAIN. DivStart held until DivFim falls.
2. Divide by zero: OpDiv with DivisorIn=0, HI=LO=0x1234 preloaded -> DivStart never rises, ExcDivZero one cycle, HI/LO still 0x1234, Ocupado high exactly 1 cycle.
3. Mult: MultHi=0xFFFFFFFF, MultLo=0xFFFFFFFE (-2) -> HiOut/LoOut match; then mthi 0xA5A5A5A5 -> HiOut=0xA5A5A5A5, LoOut unchanged.
4. Timeout: OpDiv, DivFim tied 0 -> ExcTimeout at cycle TIMEOUT, DivStart drops, HI/LO unchanged, back to IDLE.
5. Simultaneous OpMult=OpDiv=1 with HiWrite=1 -> MULT_RUN only, DivStart stays 0, HI takes WriteData then the mult result.
6. Reset asserted mid DIV_RUN (counter=15) -> all outputs 0 immediately without a clock edge; the next OpDiv after release completes normally.
